alu_wb_sched: RTL and testbench



---
 rtl/alu_wb_sched.sv | 200 ++++++++++++++++++++
 tb/tb_alu_wb_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_sched.sv
// alu_wb_sched: writeback scheduler and scoreboard for the Cardinal ALU.
// Each accepted op reserves the writeback slot matching its unit latency.
// Issue stalls on writeback-port collisions and on RAW/WAW register hazards.
// The one unit result due each cycle is steered to the single register-file write port.
// Optional feature macro: ALU_WB_FLUSH_EN adds a flush input that empties the
// table and masks late unit results for MAX_LAT cycles afterwards.
module alu_wb_sched #(
    parameter int DATA_W    = 64,
    parameter int RADDR_W   = 5,
    parameter int NUM_UNITS = 4,
    parameter int MAX_LAT   = 8,
    parameter int LAT_W     = 4,
    parameter int UT_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef ALU_WB_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic                        issue_v,
    input  logic [UT_W-1:0]             issue_unit,
    input  logic [LAT_W-1:0]            issue_lat,
    input  logic [RADDR_W-1:0]          issue_rd,
    input  logic [RADDR_W-1:0]          issue_rs1,
    input  logic [RADDR_W-1:0]          issue_rs2,
    input  logic [1:0]                  issue_rs_v,
    output logic                        issue_accept,
    output logic                        issue_stall,
    input  logic [NUM_UNITS-1:0]        unit_v,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    output logic                        wb_v,
    output logic [RADDR_W-1:0]          wb_rd,
    output logic [DATA_W-1:0]           wb_data,
    output logic [LAT_W:0]              pending_cnt,
    output logic                        err
);

    localparam int CNT_W   = LAT_W + 1;
    localparam int DRAIN_W = $clog2(MAX_LAT + 1);

    // Reservation table: slot j describes the writeback j cycles from now.
    logic [MAX_LAT-1:0] slot_v;
    logic [RADDR_W-1:0] slot_rd   [MAX_LAT];
    logic [UT_W-1:0]    slot_unit [MAX_LAT];
    logic               err_r;
    logic [CNT_W-1:0]   pending_r;

    logic [MAX_LAT-1:0] nxt_v;
    logic [RADDR_W-1:0] nxt_rd   [MAX_LAT];
    logic [UT_W-1:0]    nxt_unit [MAX_LAT];
    logic [CNT_W-1:0]   nxt_cnt;

    logic [DATA_W-1:0]    unit_res [NUM_UNITS];
    logic                 flush_s;
    logic [NUM_UNITS-1:0] drain_mask;
    logic                 lat_ok;
    logic                 port_busy;
    logic                 hazard;
    logic                 accept_s;
    logic                 missing_s;
    logic                 spurious_s;
    logic [NUM_UNITS-1:0] due_s;

`ifdef ALU_WB_FLUSH_EN
    logic [DRAIN_W-1:0] drain_cnt [NUM_UNITS];

    assign flush_s = flush;

    // Per-unit drain window: results of flushed ops may still trickle in.
    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (reset) begin
                drain_cnt[u] <= DRAIN_W'(0);
            end else if (flush) begin
                drain_cnt[u] <= DRAIN_W'(MAX_LAT);
            end else if (drain_cnt[u] != DRAIN_W'(0)) begin
                drain_cnt[u] <= drain_cnt[u] - DRAIN_W'(1);
            end else begin
                drain_cnt[u] <= drain_cnt[u];
            end
        end
    end

    // A unit is masked during flush and while its drain window is open.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            drain_mask[u] = flush || (drain_cnt[u] != DRAIN_W'(0));
        end
    end
`else
    assign flush_s    = 1'b0;
    assign drain_mask = {NUM_UNITS{1'b0}};
`endif

    // Unpack the flattened unit result bus.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_res[u] = unit_data[u*DATA_W +: DATA_W];
        end
    end

    // Issue decision: legal latency, free writeback slot, no register hazard.
    always_comb begin
        lat_ok    = (issue_lat <= LAT_W'(MAX_LAT));
        port_busy = 1'b0;
        hazard    = 1'b0;
        for (int j = 0; j < MAX_LAT; j++) begin
            if (slot_v[j]) begin
                if (issue_lat == LAT_W'(j)) port_busy = 1'b1;
                if (slot_rd[j] == issue_rd) hazard = 1'b1;
                if (issue_rs_v[0] && (slot_rd[j] == issue_rs1)) hazard = 1'b1;
                if (issue_rs_v[1] && (slot_rd[j] == issue_rs2)) hazard = 1'b1;
            end else begin
                hazard = hazard;
            end
        end
        accept_s = issue_v && !reset && !flush_s && lat_ok && !port_busy && !hazard;
    end

    // Writeback steering: reserved slot 0 first, else a same-cycle (L=0) op.
    always_comb begin
        wb_v      = 1'b0;
        wb_rd     = {RADDR_W{1'b0}};
        wb_data   = {DATA_W{1'b0}};
        due_s     = {NUM_UNITS{1'b0}};
        missing_s = 1'b0;
        if (!flush_s && slot_v[0]) begin
            wb_v                = 1'b1;
            wb_rd               = slot_rd[0];
            due_s[slot_unit[0]] = 1'b1;
            if (unit_v[slot_unit[0]]) begin
                wb_data = unit_res[slot_unit[0]];
            end else begin
                missing_s = 1'b1;
            end
        end else if (accept_s && (issue_lat == LAT_W'(0))) begin
            wb_v              = 1'b1;
            wb_rd             = issue_rd;
            wb_data           = unit_res[issue_unit];
            due_s[issue_unit] = 1'b1;
        end else begin
            wb_v = 1'b0;
        end
        spurious_s = |(unit_v & ~due_s & ~drain_mask);
    end

    // Next table: shift toward slot 0, then insert the newly accepted op.
    always_comb begin
        for (int j = 0; j < MAX_LAT - 1; j++) begin
            nxt_v[j]    = slot_v[j+1];
            nxt_rd[j]   = slot_rd[j+1];
            nxt_unit[j] = slot_unit[j+1];
        end
        nxt_v[MAX_LAT-1]    = 1'b0;
        nxt_rd[MAX_LAT-1]   = {RADDR_W{1'b0}};
        nxt_unit[MAX_LAT-1] = {UT_W{1'b0}};
        for (int j = 0; j < MAX_LAT; j++) begin
            if (flush_s) begin
                nxt_v[j] = 1'b0;
            end else if (accept_s && (issue_lat == LAT_W'(j + 1))) begin
                nxt_v[j]    = 1'b1;
                nxt_rd[j]   = issue_rd;
                nxt_unit[j] = issue_unit;
            end else begin
                nxt_v[j] = nxt_v[j];
            end
        end
        nxt_cnt = CNT_W'(0);
        for (int j = 0; j < MAX_LAT; j++) begin
            nxt_cnt = nxt_cnt + CNT_W'(nxt_v[j]);
        end
    end

    // Table, occupancy count and sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_v    <= {MAX_LAT{1'b0}};
            err_r     <= 1'b0;
            pending_r <= CNT_W'(0);
            for (int j = 0; j < MAX_LAT; j++) begin
                slot_rd[j]   <= {RADDR_W{1'b0}};
                slot_unit[j] <= {UT_W{1'b0}};
            end
        end else begin
            slot_v    <= nxt_v;
            err_r     <= err_r | (issue_v && !lat_ok) | missing_s | spurious_s;
            pending_r <= nxt_cnt;
            for (int j = 0; j < MAX_LAT; j++) begin
                slot_rd[j]   <= nxt_rd[j];
                slot_unit[j] <= nxt_unit[j];
            end
        end
    end

    assign issue_accept = accept_s;
    assign issue_stall  = issue_v && !accept_s;
    assign pending_cnt  = pending_r;
    assign err          = err_r;

endmodule

// File: tb/tb_alu_wb_sched.sv
// tb_alu_wb_sched: directed scenarios plus randomized traffic checked against a
// timed-op queue model (each pending op remembers its absolute writeback cycle).
module tb_alu_wb_sched;

    localparam int DATA_W    = 64;
    localparam int RADDR_W   = 5;
    localparam int NUM_UNITS = 4;
    localparam int MAX_LAT   = 8;
    localparam int LAT_W     = 4;

    logic                        clk;
    logic                        reset;
    logic                        flush;
    logic                        issue_v;
    logic [1:0]                  issue_unit;
    logic [LAT_W-1:0]            issue_lat;
    logic [RADDR_W-1:0]          issue_rd;
    logic [RADDR_W-1:0]          issue_rs1;
    logic [RADDR_W-1:0]          issue_rs2;
    logic [1:0]                  issue_rs_v;
    logic                        issue_accept;
    logic                        issue_stall;
    logic [NUM_UNITS-1:0]        unit_v;
    logic [NUM_UNITS*DATA_W-1:0] unit_data;
    logic                        wb_v;
    logic [RADDR_W-1:0]          wb_rd;
    logic [DATA_W-1:0]           wb_data;
    logic [LAT_W:0]              pending_cnt;
    logic                        err;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int               t;
        logic [RADDR_W-1:0] rd;
        logic [1:0]       unit;
    } op_t;

    op_t pend[$];
    int  now = 0;
    int  flush_end = -100;
    bit  m_err = 1'b0;

    alu_wb_sched dut (
        .clk(clk),
        .reset(reset),
`ifdef ALU_WB_FLUSH_EN
        .flush(flush),
`endif
        .issue_v(issue_v),
        .issue_unit(issue_unit),
        .issue_lat(issue_lat),
        .issue_rd(issue_rd),
        .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2),
        .issue_rs_v(issue_rs_v),
        .issue_accept(issue_accept),
        .issue_stall(issue_stall),
        .unit_v(unit_v),
        .unit_data(unit_data),
        .wb_v(wb_v),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .pending_cnt(pending_cnt),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: would the current issue request be accepted?
    function automatic bit m_acc_f();
        if (!issue_v || reset || flush || issue_lat > 4'd8) return 1'b0;
        foreach (pend[i]) begin
            if (pend[i].t == now + int'(issue_lat)) return 1'b0;
            if (pend[i].rd == issue_rd) return 1'b0;
            if (issue_rs_v[0] && pend[i].rd == issue_rs1) return 1'b0;
            if (issue_rs_v[1] && pend[i].rd == issue_rs2) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Model: index of the op writing back this cycle, or -1.
    function automatic int m_due_idx();
        foreach (pend[i]) if (pend[i].t == now) return i;
        return -1;
    endfunction

    task automatic idle();
        issue_v    = 1'b0;
        issue_unit = 2'd0;
        issue_lat  = 4'd0;
        issue_rd   = 5'd0;
        issue_rs1  = 5'd0;
        issue_rs2  = 5'd0;
        issue_rs_v = 2'b00;
        unit_v     = 4'b0000;
        unit_data  = '0;
        flush      = 1'b0;
    endtask

    task automatic set_issue(input int u, input int lat, input int rd);
        issue_v    = 1'b1;
        issue_unit = 2'(u);
        issue_lat  = 4'(lat);
        issue_rd   = 5'(rd);
    endtask

    task automatic set_result(input int u, input logic [DATA_W-1:0] d);
        unit_v[u] = 1'b1;
        unit_data[u*DATA_W +: DATA_W] = d;
    endtask

    // Advance the model by one clock using the inputs currently applied, then wait.
    task automatic tick();
        bit acc;
        bit [NUM_UNITS-1:0] due;
        bit masked;
        op_t op;
        acc = m_acc_f();
        due = '0;
        if (reset) begin
            pend.delete();
            m_err = 1'b0;
            flush_end = -100;
        end else begin
            if (issue_v && issue_lat > 4'd8) m_err = 1'b1;
            foreach (pend[i]) begin
                if (pend[i].t == now && !flush) begin
                    due[pend[i].unit] = 1'b1;
                    if (!unit_v[pend[i].unit]) m_err = 1'b1;
                end
            end
            if (acc && issue_lat == 4'd0) due[issue_unit] = 1'b1;
            masked = flush || (now <= flush_end);
            if (!masked && ((unit_v & ~due) != 4'b0000)) m_err = 1'b1;
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].t <= now || flush) pend.delete(i);
            end
            if (flush) flush_end = now + MAX_LAT;
            if (acc && issue_lat != 4'd0) begin
                op.t = now + int'(issue_lat);
                op.rd = issue_rd;
                op.unit = issue_unit;
                pend.push_back(op);
            end
        end
        now++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        set_issue(1, 1, 2);
        #1;
        checks++; if (issue_accept !== 1'b0) $display("FAIL reset_accept: got %b want 0", issue_accept); else passes++;
        tick();
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++; if (pending_cnt !== 5'd0) $display("FAIL reset_pending: got %0d want 0", pending_cnt); else passes++;
        checks++; if (wb_v !== 1'b0) $display("FAIL reset_wb_v: got %b want 0", wb_v); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        idle(); set_issue(1, 2, 7); #1;
        checks++; if (issue_accept !== 1'b1) $display("FAIL basic_accept: got %b want 1", issue_accept); else passes++;
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 5'd1) $display("FAIL basic_pending1: got %0d want 1", pending_cnt); else passes++;
        checks++; if (wb_v !== 1'b0) $display("FAIL basic_early_wb: got %b want 0", wb_v); else passes++;
        tick();
        idle(); set_result(1, 64'hDEAD); #1;
        checks++; if (wb_v !== 1'b1) $display("FAIL basic_wb_v: got %b want 1", wb_v); else passes++;
        checks++; if (wb_rd !== 5'd7) $display("FAIL basic_wb_rd: got %0d want 7", wb_rd); else passes++;
        checks++; if (wb_data !== 64'hDEAD) $display("FAIL basic_wb_data: got %h want dead", wb_data); else passes++;
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 5'd0) $display("FAIL basic_pending0: got %0d want 0", pending_cnt); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else passes++;
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        idle(); set_issue(1, 3, 4); #1;
        checks++; if (issue_accept !== 1'b1) $display("FAIL coll_first: got %b want 1", issue_accept); else passes++;
        tick();
        idle(); set_issue(2, 2, 5); #1;
        checks++; if (issue_stall !== 1'b1) $display("FAIL coll_stall: got %b want 1", issue_stall); else passes++;
        tick();
        idle(); set_issue(2, 2, 5); #1;
        checks++; if (issue_accept !== 1'b1) $display("FAIL coll_retry: got %b want 1", issue_accept); else passes++;
        tick();
        idle(); set_result(1, 64'h1111_0004); #1;
        checks++; if (wb_v !== 1'b1 || wb_rd !== 5'd4) $display("FAIL coll_wb4: got v=%b rd=%0d want v=1 rd=4", wb_v, wb_rd); else passes++;
        tick();
        idle(); set_result(2, 64'h2222_0005); #1;
        checks++; if (wb_v !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'h2222_0005) $display("FAIL coll_wb5: got v=%b rd=%0d data=%h want v=1 rd=5 data=22220005", wb_v, wb_rd, wb_data); else passes++;
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        idle(); set_issue(3, 5, 9); #1;
        checks++; if (issue_accept !== 1'b1) $display("FAIL raw_producer: got %b want 1", issue_accept); else passes++;
        tick();
        for (int k = 1; k <= 6; k++) begin
            idle(); set_issue(0, 1, 10); issue_rs1 = 5'd9; issue_rs_v = 2'b01;
            if (k == 5) set_result(3, 64'h9);
            #1;
            checks++; if (issue_accept !== (k == 6)) $display("FAIL raw_accept_k%0d: got %b want %b", k, issue_accept, (k == 6)); else passes++;
            tick();
        end
        idle(); set_result(0, 64'hA); #1;
        checks++; if (wb_v !== 1'b1 || wb_rd !== 5'd10) $display("FAIL raw_consumer_wb: got v=%b rd=%0d want v=1 rd=10", wb_v, wb_rd); else passes++;
        tick();
        idle(); set_issue(3, 5, 9); tick();
        idle(); set_issue(0, 1, 10); issue_rs1 = 5'd9; issue_rs_v = 2'b00; #1;
        checks++; if (issue_accept !== 1'b1) $display("FAIL raw_novalid: got %b want 1", issue_accept); else passes++;
        tick();
        for (int k = 2; k <= 5; k++) begin
            idle();
            if (k == 2) set_result(0, 64'hA);
            if (k == 5) set_result(3, 64'h9);
            #1;
            if (k == 5) begin
                checks++; if (wb_rd !== 5'd9) $display("FAIL raw_late_wb: got rd=%0d want 9", wb_rd); else passes++;
            end
            tick();
        end
        idle(); #1;
        checks++; if (err !== 1'b0) $display("FAIL raw_err: got %b want 0", err); else passes++;
        tick();
    endtask

    task automatic test_lat0();
        do_reset();
        idle(); set_issue(0, 0, 3); set_result(0, 64'h55); #1;
        checks++; if (issue_accept !== 1'b1 || wb_v !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 64'h55) $display("FAIL lat0_wb: got acc=%b v=%b rd=%0d data=%h want 1 1 3 55", issue_accept, wb_v, wb_rd, wb_data); else passes++;
        tick();
        idle(); set_issue(2, 1, 6); tick();
        idle(); set_issue(0, 0, 3); set_result(2, 64'h66); #1;
        checks++; if (issue_stall !== 1'b1) $display("FAIL lat0_stall: got %b want 1", issue_stall); else passes++;
        checks++; if (wb_rd !== 5'd6 || wb_data !== 64'h66) $display("FAIL lat0_slot_wb: got rd=%0d data=%h want 6 66", wb_rd, wb_data); else passes++;
        tick();
        idle(); #1;
        checks++; if (err !== 1'b0) $display("FAIL lat0_err: got %b want 0", err); else passes++;
        tick();
    endtask

    task automatic test_errors();
        do_reset();
        idle(); set_issue(2, 1, 8); tick();
        idle(); #1;
        checks++; if (wb_v !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 64'd0) $display("FAIL missing_wb: got v=%b rd=%0d data=%h want 1 8 0", wb_v, wb_rd, wb_data); else passes++;
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(); #1;
            checks++; if (err !== 1'b1) $display("FAIL missing_err_sticky%0d: got %b want 1", k, err); else passes++;
            tick();
        end
        do_reset();
        idle(); set_result(3, 64'h3); #1;
        checks++; if (err !== 1'b0) $display("FAIL spurious_pre: got %b want 0", err); else passes++;
        tick();
        idle(); #1;
        checks++; if (err !== 1'b1) $display("FAIL spurious_err: got %b want 1", err); else passes++;
        tick();
        do_reset();
        idle(); set_issue(1, 9, 12); #1;
        checks++; if (issue_accept !== 1'b0 || issue_stall !== 1'b1) $display("FAIL badlat_accept: got acc=%b stall=%b want 0 1", issue_accept, issue_stall); else passes++;
        tick();
        idle(); #1;
        checks++; if (err !== 1'b1) $display("FAIL badlat_err: got %b want 1", err); else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        idle(); set_issue(1, 3, 1); tick();
        idle(); set_issue(2, 3, 2); tick();
        idle(); set_issue(3, 3, 11); #1;
        checks++; if (pending_cnt !== 5'd2) $display("FAIL mid_pending_pre: got %0d want 2", pending_cnt); else passes++;
        tick();
        idle(); reset = 1'b1; tick();
        reset = 1'b0;
        idle(); set_result(2, 64'h2); #1;
        checks++; if (pending_cnt !== 5'd0 || wb_v !== 1'b0 || err !== 1'b0 || issue_accept !== 1'b0) $display("FAIL mid_after_reset: got cnt=%0d v=%b err=%b acc=%b want 0 0 0 0", pending_cnt, wb_v, err, issue_accept); else passes++;
        tick();
        idle(); #1;
        checks++; if (err !== 1'b1) $display("FAIL mid_late_result: got %b want 1", err); else passes++;
        tick();
    endtask

`ifdef ALU_WB_FLUSH_EN
    task automatic test_flush();
        do_reset();
        idle(); set_issue(1, 3, 1); tick();
        idle(); set_issue(2, 3, 2); tick();
        idle(); set_issue(3, 3, 11); tick();
        idle(); flush = 1'b1; set_issue(0, 1, 20); set_result(1, 64'h1); #1;
        checks++; if (issue_accept !== 1'b0 || wb_v !== 1'b0) $display("FAIL flush_outputs: got acc=%b v=%b want 0 0", issue_accept, wb_v); else passes++;
        tick();
        idle(); set_result(2, 64'h2); #1;
        checks++; if (pending_cnt !== 5'd0) $display("FAIL flush_pending: got %0d want 0", pending_cnt); else passes++;
        tick();
        idle(); set_result(3, 64'h3); tick();
        idle(); #1;
        checks++; if (err !== 1'b0) $display("FAIL flush_err: got %b want 0", err); else passes++;
        tick();
    endtask
`endif

    task automatic test_random();
        bit exp_acc;
        bit exp_v;
        logic [RADDR_W-1:0] exp_rd;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W-1:0] d;
        int di;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            idle();
            issue_v    = ($urandom_range(0, 2) != 0);
            issue_unit = 2'($urandom_range(0, 3));
            issue_lat  = 4'($urandom_range(0, 8));
            issue_rd   = 5'($urandom_range(0, 7));
            issue_rs1  = 5'($urandom_range(0, 7));
            issue_rs2  = 5'($urandom_range(0, 7));
            issue_rs_v = 2'($urandom_range(0, 3));
            exp_acc = m_acc_f();
            exp_v = 1'b0; exp_rd = '0; exp_data = '0;
            d = {$urandom, $urandom};
            di = m_due_idx();
            if (di >= 0) begin
                set_result(int'(pend[di].unit), d);
                exp_v = 1'b1; exp_rd = pend[di].rd; exp_data = d;
            end else if (exp_acc && issue_lat == 4'd0) begin
                set_result(int'(issue_unit), d);
                exp_v = 1'b1; exp_rd = issue_rd; exp_data = d;
            end
            #1;
            checks++; if (issue_accept !== exp_acc) $display("FAIL rnd_accept c%0d: got %b want %b", c, issue_accept, exp_acc); else passes++;
            checks++; if (issue_stall !== (issue_v && !exp_acc)) $display("FAIL rnd_stall c%0d: got %b want %b", c, issue_stall, issue_v && !exp_acc); else passes++;
            checks++; if (wb_v !== exp_v || wb_rd !== exp_rd || wb_data !== exp_data) $display("FAIL rnd_wb c%0d: got v=%b rd=%0d data=%h want v=%b rd=%0d data=%h", c, wb_v, wb_rd, wb_data, exp_v, exp_rd, exp_data); else passes++;
            checks++; if (pending_cnt !== 5'(pend.size())) $display("FAIL rnd_pending c%0d: got %0d want %0d", c, pending_cnt, pend.size()); else passes++;
            checks++; if (err !== m_err) $display("FAIL rnd_err c%0d: got %b want %b", c, err, m_err); else passes++;
            tick();
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_collision();
        test_raw();
        test_lat0();
        test_errors();
        test_reset_mid();
`ifdef ALU_WB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
